// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input, in clock cycles.
// Latency: results and valid appear SYNC_STAGES+1 cycles after the closing input rising edge.
// Backpressure: none; valid and overflow are single-cycle strobes with no handshake.
module pwm_capture #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             resetPWM,
    input  logic             startCapture,
    input  logic             pwmIn,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty,
    output logic             valid,
    output logic             overflow,
    output logic             level,
    output logic             busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   s;
    logic                   sPrev;
    logic                   rise;
    logic                   fall;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       highCnt;

    assign s    = syncReg[SYNC_STAGES-1];
    assign rise = s & ~sPrev;
    assign fall = ~s & sPrev;
    assign busy = (state == ARM) || (state == MEASURE);

    always_ff @(posedge clock) begin
        if (resetPWM) begin
            state    <= IDLE;
            syncReg  <= '0;
            sPrev    <= 1'b0;
            cnt      <= '0;
            highCnt  <= '0;
            period   <= '0;
            duty     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            level    <= 1'b0;
        end else begin
            syncReg  <= {syncReg[SYNC_STAGES-2:0], pwmIn};
            sPrev    <= s;
            valid    <= 1'b0;
            overflow <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (startCapture) begin
                        state <= ARM;
                    end
                end

                ARM: begin
                    // No prior edge yet, so the first rise only starts a measurement.
                    if (!startCapture) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (rise) begin
                        state <= MEASURE;
                        cnt   <= ONE;
                    end else if (cnt == MAX) begin
                        overflow <= 1'b1;
                        level    <= s;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                MEASURE: begin
                    // A rise at cnt == MAX is still a legal period, so it outranks the timeout.
                    if (!startCapture) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (rise) begin
                        period <= cnt;
                        duty   <= highCnt;
                        valid  <= 1'b1;
                        cnt    <= ONE;
                    end else if (cnt == MAX) begin
                        overflow <= 1'b1;
                        level    <= s;
                        state    <= ARM;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                        if (fall) begin
                            highCnt <= cnt;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
